// File: rtl/uart_tx.sv
// uart_tx: valid/ready word in, one UART frame out (start, DLEN data LSB-first, optional parity, stop bits)
module uart_tx #(
    parameter int BAUD      = 25000000,
    parameter int CLKF      = 100000000,
    parameter int DLEN      = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_tvalid,
    output logic            o_tready,
    input  logic [DLEN-1:0] i_tdata,
    output logic            o_txs,
    output logic            o_busy
);
    localparam int N  = CLKF / BAUD;
    localparam int CW = (N < 2) ? 1 : $clog2(N);
    localparam int BW = $clog2(DLEN + 1);
    if (N < 2) begin : g_bad_n
        $error("uart_tx: CLKF/BAUD must be at least 2");
    end
    if (DLEN < 5 || DLEN > 9) begin : g_bad_dlen
        $error("uart_tx: DLEN must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        PAR   = 5'b01000,
        STOP  = 5'b10000
    } state_t;
    state_t          st;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bc;
    logic [DLEN-1:0] sh;
    logic            par;
    logic            tick;
    assign tick = cnt == CW'(N - 1);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st       <= IDLE;
            cnt      <= '0;
            bc       <= '0;
            sh       <= '0;
            par      <= 1'b0;
            o_txs    <= 1'b1;
            o_tready <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            cnt <= (st == IDLE || tick) ? '0 : cnt + CW'(1);
            case (st)
                IDLE: begin
                    bc <= '0;
                    if (i_tvalid && o_tready) begin
                        sh       <= i_tdata;
                        par      <= (PARITY == 2) ^ (^i_tdata);
                        st       <= START;
                        o_txs    <= 1'b0;
                        o_busy   <= 1'b1;
                        o_tready <= 1'b0;
                    end else begin
                        o_txs    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_tready <= 1'b1;
                    end
                end
                START: if (tick) begin
                    st    <= DATA;
                    o_txs <= sh[0];
                end
                DATA: if (tick) begin
                    if (bc == BW'(DLEN - 1)) begin
                        bc    <= '0;
                        st    <= (PARITY != 0) ? PAR : STOP;
                        o_txs <= (PARITY != 0) ? par : 1'b1;
                    end else begin
                        bc    <= bc + BW'(1);
                        sh    <= sh >> 1;
                        o_txs <= sh[1];
                    end
                end
                PAR: if (tick) begin
                    st    <= STOP;
                    o_txs <= 1'b1;
                end
                STOP: if (tick) begin
                    if (bc == BW'(STOP_BITS - 1)) begin
                        bc       <= '0;
                        st       <= IDLE;
                        o_busy   <= 1'b0;
                        o_tready <= 1'b1;
                    end else begin
                        bc <= bc + BW'(1);
                    end
                end
                default: begin
                    st       <= IDLE;
                    bc       <= '0;
                    o_txs    <= 1'b1;
                    o_busy   <= 1'b0;
                    o_tready <= 1'b0;
                    $error("uart_tx: illegal state %b", st);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter configurations (8N1, 8O2, 8E1) at 4 clocks per bit, checked cycle by cycle
module tb_uart_tx;
    localparam int NB = 4;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] tv = '0;
    logic [2:0] tr, txs, busy;
    logic [7:0] td [3];
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    uart_tx #(.BAUD(25000000), .CLKF(100000000), .DLEN(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rstn(rstn), .i_tvalid(tv[0]), .o_tready(tr[0]), .i_tdata(td[0]), .o_txs(txs[0]), .o_busy(busy[0]));
    uart_tx #(.BAUD(25000000), .CLKF(100000000), .DLEN(8), .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rstn(rstn), .i_tvalid(tv[1]), .o_tready(tr[1]), .i_tdata(td[1]), .o_txs(txs[1]), .o_busy(busy[1]));
    uart_tx #(.BAUD(25000000), .CLKF(100000000), .DLEN(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rstn(rstn), .i_tvalid(tv[2]), .o_tready(tr[2]), .i_tdata(td[2]), .o_txs(txs[2]), .o_busy(busy[2]));
    function automatic int par_of(input int k);
        return k == 1 ? 2 : (k == 2 ? 1 : 0);
    endfunction
    function automatic int sb_of(input int k);
        return k == 1 ? 2 : 1;
    endfunction
    // expected line level for frame bit j: start, data LSB-first, optional parity, then stop
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (j == 9 && par_of(k) == 1) return ^d;
        if (j == 9 && par_of(k) == 2) return ~^d;
        return 1'b1;
    endfunction
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask
    // called at a negedge; drives one handshake and follows the whole frame
    task automatic send(input int k, input logic [7:0] d, input bit hold, input bit noise);
        int f, w;
        logic [7:0] rx;
        f = (9 + (par_of(k) != 0 ? 1 : 0) + sb_of(k)) * NB;
        rx = '0;
        w = 0;
        while (!tr[k] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("tready_before_send%0d", k), 32'(tr[k]), 1);
        tv[k] = 1'b1;
        td[k] = d;
        @(negedge clk);
        if (!hold) tv[k] = 1'b0;
        for (int i = 0; i < f; i++) begin
            chk($sformatf("txs%0d_c%0d", k, i), 32'(txs[k]), 32'(exp_bit(k, d, i / NB)));
            chk($sformatf("rdy_busy%0d_c%0d", k, i), 32'({tr[k], busy[k]}), 32'(2'b01));
            if (i % NB == NB / 2 && i / NB >= 1 && i / NB <= 8) rx[i/NB-1] = txs[k];
            if (noise) begin
                tv[k] = 1'($urandom);
                td[k] = 8'($urandom);
            end
            @(negedge clk);
        end
        tv[k] = hold;
        chk($sformatf("rx_byte%0d", k), 32'(rx), 32'(d));
        chk($sformatf("idle_after%0d", k), 32'({tr[k], busy[k], txs[k]}), 32'(3'b101));
    endtask
    initial begin
        for (int k = 0; k < 3; k++) td[k] = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("reset_outs", 32'({txs, tr, busy}), 32'({3'b111, 3'b000, 3'b000}));
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset", 32'({txs, tr, busy}), 32'({3'b111, 3'b111, 3'b000}));
        send(0, 8'hA5, 0, 0);
        send(0, 8'h00, 1, 0);
        send(0, 8'hFF, 0, 0);
        @(negedge clk);
        chk("still_idle", 32'({tr[0], busy[0], txs[0]}), 32'(3'b101));
        send(1, 8'h07, 0, 0);
        send(2, 8'h07, 0, 0);
        send(0, 8'h5A, 0, 1);
        tv[0] = 1'b1;
        td[0] = 8'h55;
        @(negedge clk);
        tv[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_bit3", 32'(txs[0]), 0);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_reset", 32'({txs[0], tr[0], busy[0]}), 32'(3'b100));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_release", 32'({txs[0], tr[0], busy[0]}), 32'(3'b110));
        send(0, 8'h81, 0, 0);
        for (int r = 0; r < 12; r++) send(r % 3, 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
        tv = '0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that pairs with the team's `uart_rx` receiver. It accepts a parallel word over a valid/ready handshake and serialises it onto the TX line as one frame: a start bit, DLEN data bits LSB-first, an optional parity bit, then one or two stop bits. The block sits between the host-side producer (FIFO or register interface) and the device pin. A frame at default parameters is byte-compatible with `uart_rx`.

## Interface
- `BAUD`, 25000000: line bit rate in bits/s.
- `CLKF`, 100000000: clk frequency in Hz. N = CLKF/BAUD (integer division) is the clocks per bit. N < 2 is an elaboration `$error`.
- `DLEN`, 8: data bits per frame. The legal range is 5..9; anything else is an elaboration `$error`.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd. Any other value is an elaboration `$error`.
- `STOP_BITS`, 1: number of stop bits, 1 or 2. Any other value is an elaboration `$error`.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low. Clock is clk.
- `i_tvalid`  in  1  producer has a word to send.
- `o_tready`  out  1  block can accept a word. Registered. Reset value 0.
- `i_tdata`  in  DLEN  word to send. Sampled only on handshake.
- `o_txs`  out  1  serial line, idle-high. Registered. Reset value 1.
- `o_busy`  out  1  a frame is in progress. Registered. Reset value 0.

## Operation
- State machine has four states: IDLE, START, DATA, STOP (plus PARITY when PARITY != 0). Encoding is one-hot. An illegal state goes to IDLE and raises a simulation `$error` when rstn=1.
- IDLE:
  - o_tready=1, o_txs=1, o_busy=0.
  - A handshake is i_tvalid && o_tready in the same cycle.
  - On handshake: latch i_tdata into the shift register, compute the parity bit from the latched data, go to START.
- START: o_txs=0 for N cycles, then go to DATA.
- DATA:
  - o_txs = shift register bit 0 for N cycles per bit.
  - At each bit boundary, shift right by one.
  - After DLEN bits, go to PARITY if enabled, else STOP.
- PARITY: o_txs = parity bit for N cycles.
  - Even: bit = ^data.
  - Odd: bit = ~^data.
- STOP: o_txs=1 for STOP_BITS×N cycles, then go to IDLE.
- Baud counter:
  - Counts 0..N-1. The bit boundary is count == N-1; the counter then wraps to 0.
  - Held at 0 in IDLE and cleared on entry to START.
- Bit counter counts 0..DLEN-1 in DATA and 0..STOP_BITS-1 in STOP. Width is $clog2(DLEN+1).
- o_busy=1 in every state except IDLE. o_tready = !o_busy, registered so it is never high during reset.
- i_tdata and i_tvalid are ignored outside the handshake cycle. Changes to i_tdata after the handshake do not affect the frame in flight.

## Timing
- Handshake at cycle t. o_txs falls at cycle t+1, registered, so latency is 1.
- Frame bits = 1 + DLEN + (PARITY?1:0) + STOP_BITS. F = bits × N.
- o_txs is valid on cycles t+1 .. t+F. Each bit is exactly N cycles.
- o_tready and o_busy change in the same cycle that o_txs falls.
  - o_tready=0 and o_busy=1 on cycles t+1 .. t+F.
  - o_tready=1 and o_busy=0 again at cycle t+F+1.
- Back-to-back: with i_tvalid held high, the next handshake is at t+F+1. The next start bit begins at t+F+2, giving exactly one clk of idle-high between frames.
- Reset while rstn=0:
  - o_txs=1, o_tready=0, o_busy=0, state=IDLE, counters=0.
  - A frame interrupted by reset is abandoned and never resumed.
  - o_tready=1 on the first clk after rstn rises.

## Test plan
- Reset and idle: rstn=0 for 5 clk, then release with i_tvalid=0. Required: o_txs=1 throughout. o_tready=0 during reset and 1 from the 1st clk after release. o_busy=0 throughout.
- Single 8N1 frame at N=4, i_tdata=0xA5. Required:
  - o_txs reads 0, 1,0,1,0,0,1,0,1, 1, each held for 4 clk.
  - The first 0 appears 1 clk after the handshake.
  - o_tready returns 1 exactly 40 clk after o_txs falls.
- Back-to-back: i_tvalid held high with 0x00 then 0xFF. Required: two frames separated by exactly 1 idle-high clk, and o_tready pulses high for 1 clk between them.
- Parity and stop bits, PARITY=2, STOP_BITS=2, i_tdata=0x07:
  - Parity bit = 0, because three ones under odd parity give 0.
  - Stop is high for 8 clk. The frame is 48 clk long.
  - Repeat with PARITY=1: parity bit = 1.
- Data stability: change i_tdata to 0x3C mid-frame after sending 0x5A. Required: the line carries 0x5A unaltered. i_tvalid pulses while busy cause no handshake.
- Reset mid-frame: assert rstn=0 during bit 3 of a frame. Required: o_txs=1 on the next clk. After release, a new word 0x81 is sent as a complete, correct frame. Loopback into `uart_rx` yields o_rdata=0x81 with one o_rvalid pulse.
